stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_if.sv | 47 ++++
 rtl/stage_sequencer.sv | 125 ++++++++++++
 tb/tb_stage_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : stage_sequencer_if
//  Purpose  : Control/handshake bundle between the stage sequencer and its core
//  Revision : 1.0  initial release
// ============================================================================
interface stage_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             cond_pass;
  logic             is_branch;
  logic             is_mem;
  logic             writes_reg;
  logic             set_flags;
  logic             mem_ready;

  logic             if_en;
  logic             rf_en;
  logic             ex_en;
  logic             dm_en;
  logic             wb_en;
  logic             mem_req;
  logic             cpsr_we;
  logic             rf_write;
  logic             pc_incr;
  logic             pc_branch;
  logic             busy;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  // Core side: drives instruction attributes, consumes stage controls
  modport master (
    output run, cond_pass, is_branch, is_mem, writes_reg, set_flags, mem_ready,
    input  if_en, rf_en, ex_en, dm_en, wb_en, mem_req, cpsr_we, rf_write,
           pc_incr, pc_branch, busy, fault, state, instr_count
  );

  // Sequencer side
  modport slave (
    input  run, cond_pass, is_branch, is_mem, writes_reg, set_flags, mem_ready,
    output if_en, rf_en, ex_en, dm_en, wb_en, mem_req, cpsr_we, rf_write,
           pc_incr, pc_branch, busy, fault, state, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stage_sequencer
//  Purpose  : Multi-cycle IF/RF/EX/DM/WB sequencer with memory timeout fault
//  Revision : 1.0  initial release
// ============================================================================
module stage_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                nreset,
  stage_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    c_IF    = 3'b000,
    c_RF    = 3'b001,
    c_EX    = 3'b010,
    c_DM    = 3'b011,
    c_WB    = 3'b100,
    c_IDLE  = 3'b101,
    c_FAULT = 3'b110
  } stateT;

  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  stateT            r_state;
  stateT            w_stateNext;
  logic [7:0]       r_waitCnt;
  logic [CNT_W-1:0] r_instrCount;
  logic             r_ok;
  logic             r_br;
  logic             r_mm;
  logic             r_wr;
  logic             w_inDm;
  logic             w_inWb;
  logic             w_inEx;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = c_IDLE;
    case (r_state)
      c_IDLE:  w_stateNext = bus.run ? c_IF : c_IDLE;
      c_IF:    w_stateNext = c_RF;
      c_RF:    w_stateNext = c_EX;
      c_EX:    w_stateNext = (bus.cond_pass && bus.is_mem) ? c_DM : c_WB;
      // A completing handshake beats the timeout on the final allowed cycle
      c_DM: begin
        if (bus.mem_ready) begin
          w_stateNext = c_WB;
        end else if (r_waitCnt == c_WAIT_LAST) begin
          w_stateNext = c_FAULT;
        end else begin
          w_stateNext = c_DM;
        end
      end
      c_WB:    w_stateNext = bus.run ? c_IF : c_IDLE;
      c_FAULT: w_stateNext = c_FAULT;
      default: w_stateNext = c_IDLE;
    endcase
  end

  assign w_inEx = (r_state == c_EX);
  assign w_inDm = (r_state == c_DM);
  assign w_inWb = (r_state == c_WB);

  // EX is the only predecessor of DM, so clearing there is clearing on entry
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_waitCnt <= 8'd0;
    end else if (w_inEx) begin
      r_waitCnt <= 8'd0;
    end else if (w_inDm && !bus.mem_ready) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_ok <= 1'b0;
      r_br <= 1'b0;
      r_mm <= 1'b0;
      r_wr <= 1'b0;
    end else if (w_inEx) begin
      r_ok <= bus.cond_pass;
      r_br <= bus.is_branch;
      r_mm <= bus.is_mem;
      r_wr <= bus.writes_reg;
    end
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_instrCount <= '0;
    end else if (w_inWb) begin
      r_instrCount <= r_instrCount + 1'b1;
    end
  end

  assign bus.if_en       = (r_state == c_IF);
  assign bus.rf_en       = (r_state == c_RF);
  assign bus.ex_en       = w_inEx;
  assign bus.dm_en       = w_inDm;
  assign bus.wb_en       = w_inWb;
  assign bus.mem_req     = w_inDm && r_ok && r_mm;
  // Flag write must land in EX itself, so it is gated by the live condition result
  assign bus.cpsr_we     = w_inEx && bus.cond_pass && bus.set_flags;
  assign bus.rf_write    = w_inWb && r_ok && r_wr;
  assign bus.pc_branch   = w_inWb && r_ok && r_br;
  assign bus.pc_incr     = w_inWb && !(r_ok && r_br);
  assign bus.busy        = (r_state != c_IDLE) && (r_state != c_FAULT);
  assign bus.fault       = (r_state == c_FAULT);
  assign bus.state       = r_state;
  assign bus.instr_count = r_instrCount;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_sequencer
//  Purpose  : Directed and randomized self-checking bench for stage_sequencer
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage_sequencer;

  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [2:0] IF_S    = 3'b000;
  localparam logic [2:0] RF_S    = 3'b001;
  localparam logic [2:0] EX_S    = 3'b010;
  localparam logic [2:0] DM_S    = 3'b011;
  localparam logic [2:0] WB_S    = 3'b100;
  localparam logic [2:0] IDLE_S  = 3'b101;
  localparam logic [2:0] FAULT_S = 3'b110;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

  stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] modelCount;
  bit               inIdle;
  bit               faulted;

  // Expected outputs derived purely from the architectural state and WB decisions
  task automatic check_now(input string tag, input logic [2:0] st,
                           input bit cpsr, input bit rfw, input bit pinc, input bit pbr);
    logic [14:0] obsv;
    logic [14:0] expv;
    expv = {st, st == IF_S, st == RF_S, st == EX_S, st == DM_S, st == WB_S, st == DM_S,
            cpsr, rfw, pinc, pbr, (st != IDLE_S) && (st != FAULT_S), st == FAULT_S};
    obsv = {bus.state, bus.if_en, bus.rf_en, bus.ex_en, bus.dm_en, bus.wb_en, bus.mem_req,
            bus.cpsr_we, bus.rf_write, bus.pc_incr, bus.pc_branch, bus.busy, bus.fault};
    checks++;
    assert (obsv === expv) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obsv, expv);
    end
    checks++;
    assert (bus.instr_count === modelCount) else begin
      failures++;
      $error("FAIL %s instr_count observed=%0d expected=%0d", tag, bus.instr_count, modelCount);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st,
                      input bit cpsr, input bit rfw, input bit pinc, input bit pbr);
    @(negedge clk);
    check_now(tag, st, cpsr, rfw, pinc, pbr);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.run        = 1'($urandom);
    bus.cond_pass  = 1'($urandom);
    bus.is_branch  = 1'($urandom);
    bus.is_mem     = 1'($urandom);
    bus.writes_reg = 1'($urandom);
    bus.set_flags  = 1'($urandom);
    bus.mem_ready  = 1'($urandom);
  endtask

  // One instruction from IF onward; nLow = DM cycles with mem_ready low before it rises
  task automatic do_instr(input bit cp, input bit br, input bit mm, input bit wr, input bit sf,
                          input int nLow, input bit runAtWb, input bit dropRun,
                          output bit hitFault);
    hitFault = 1'b0;
    noise();
    step("IF", IF_S, 1'b0, 1'b0, 1'b0, 1'b0);
    noise();
    if (dropRun) bus.run = 1'b0;
    step("RF", RF_S, 1'b0, 1'b0, 1'b0, 1'b0);
    noise();
    if (dropRun) bus.run = 1'b0;
    bus.cond_pass  = cp;
    bus.is_branch  = br;
    bus.is_mem     = mm;
    bus.writes_reg = wr;
    bus.set_flags  = sf;
    step("EX", EX_S, cp & sf, 1'b0, 1'b0, 1'b0);
    if (cp && mm) begin
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        noise();
        if (dropRun) bus.run = 1'b0;
        bus.mem_ready = (k == nLow);
        step("DM", DM_S, 1'b0, 1'b0, 1'b0, 1'b0);
        if (k == nLow) break;
        if (k == MEM_TIMEOUT - 1) hitFault = 1'b1;
      end
    end
    if (hitFault) return;
    noise();
    bus.run = runAtWb;
    step("WB", WB_S, 1'b0, cp & wr, !(cp & br), cp & br);
    modelCount = modelCount + 1'b1;
  endtask

  task automatic run_one(input bit cp, input bit br, input bit mm, input bit wr, input bit sf,
                         input int nLow, input bit runAtWb, input bit dropRun,
                         output bit hitFault);
    if (inIdle) begin
      repeat ($urandom_range(0, 2)) begin
        noise();
        bus.run = 1'b0;
        step("IDLE", IDLE_S, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      noise();
      bus.run = 1'b1;
      step("IDLE_GO", IDLE_S, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    do_instr(cp, br, mm, wr, sf, nLow, runAtWb, dropRun, hitFault);
    inIdle = !runAtWb;
  endtask

  task automatic pulse_reset(input string tag);
    nreset = 1'b1;
    #1;
    modelCount = '0;
    check_now(tag, IDLE_S, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    nreset = 1'b0;
    inIdle = 1'b1;
  endtask

  initial begin
    nreset         = 1'b1;
    bus.run        = 1'b0;
    bus.cond_pass  = 1'b0;
    bus.is_branch  = 1'b0;
    bus.is_mem     = 1'b0;
    bus.writes_reg = 1'b0;
    bus.set_flags  = 1'b0;
    bus.mem_ready  = 1'b0;
    modelCount     = '0;
    inIdle         = 1'b1;

    // Reset dominates noisy inputs
    repeat (2) @(posedge clk);
    #1;
    noise();
    step("RESET", IDLE_S, 1'b0, 1'b0, 1'b0, 1'b0);
    nreset = 1'b0;

    // ALU op, squash, load with waits, timeout race, run dropped in RF
    run_one(1, 0, 0, 1, 1, 0, 0, 0, faulted);
    run_one(0, 1, 0, 0, 0, 0, 0, 0, faulted);
    run_one(1, 0, 1, 1, 0, 3, 1, 0, faulted);
    run_one(1, 0, 1, 1, 0, MEM_TIMEOUT - 1, 0, 0, faulted);
    run_one(1, 1, 0, 0, 1, 0, 0, 1, faulted);
    run_one(0, 0, 1, 1, 1, 0, 1, 0, faulted);
    run_one(1, 1, 1, 1, 0, 0, 0, 0, faulted);

    // Randomized traffic, long enough to wrap the counter
    for (int i = 0; i < 300; i++) begin
      run_one(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, MEM_TIMEOUT - 1), 1'($urandom), 1'($urandom), faulted);
    end

    // Explicit all-ones to zero retirement
    for (int i = 0; i < 300 && modelCount != {CNT_W{1'b1}}; i++) begin
      run_one(1, 0, 0, 0, 0, 0, 0, 0, faulted);
    end
    run_one(1, 0, 0, 1, 0, 0, 0, 0, faulted);
    @(negedge clk);
    checks++;
    assert (bus.instr_count === '0) else begin
      failures++;
      $error("FAIL WRAP instr_count observed=%0d expected=0", bus.instr_count);
    end
    @(posedge clk);
    #1;

    // Reset in the middle of a memory access
    run_one(1, 0, 0, 1, 0, 0, 0, 0, faulted);
    bus.run = 1'b1;
    step("IDLE_GO", IDLE_S, 1'b0, 1'b0, 1'b0, 1'b0);
    noise();
    step("IF", IF_S, 1'b0, 1'b0, 1'b0, 1'b0);
    noise();
    step("RF", RF_S, 1'b0, 1'b0, 1'b0, 1'b0);
    noise();
    bus.cond_pass  = 1'b1;
    bus.is_mem     = 1'b1;
    bus.writes_reg = 1'b1;
    bus.set_flags  = 1'b0;
    step("EX", EX_S, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    step("DM", DM_S, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.run = 1'b1;
    pulse_reset("RST_DM");
    run_one(1, 0, 0, 1, 1, 0, 0, 0, faulted);

    // Memory timeout then sticky fault
    run_one(1, 0, 1, 1, 0, 1000, 1, 0, faulted);
    checks++;
    assert (faulted === 1'b1) else begin
      failures++;
      $error("FAIL TIMEOUT_PATH observed=%0b expected=1", faulted);
    end
    for (int i = 0; i < 5; i++) begin
      noise();
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      step("FAULT", FAULT_S, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    pulse_reset("RST_FAULT");
    run_one(0, 0, 0, 1, 1, 0, 0, 0, faulted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
